// File: rtl/controller_led_pkg.sv
// ---------------------------------------------------------------------------
// controller_led_pkg
// Shared definitions for the multi-channel LED blinker:
//   - register select values within a channel's two-word window
//   - CTRL register bit positions
//   - ctrl_t, the writable control bits held per channel
//   - pack_ctrl(), which builds the 32-bit CTRL read word
// ---------------------------------------------------------------------------
package controller_led_pkg;

   localparam logic SEL_PERIOD = 1'b0;
   localparam logic SEL_CTRL   = 1'b1;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_INV_BIT   = 1;
   localparam int CTRL_LEVEL_BIT = 2;
   localparam int CTRL_IE_BIT    = 3;
   localparam int CTRL_PEND_BIT  = 4;

   typedef struct packed {
      logic ie;
      logic inv;
      logic en;
   } ctrl_t;

   // Unused CTRL bits always read back as zero.
   function automatic logic [31:0] pack_ctrl(ctrl_t c, logic level, logic pend);
      logic [31:0] v;
      v                 = '0;
      v[CTRL_EN_BIT]    = c.en;
      v[CTRL_INV_BIT]   = c.inv;
      v[CTRL_LEVEL_BIT] = level;
      v[CTRL_IE_BIT]    = c.ie;
      v[CTRL_PEND_BIT]  = pend;
      return v;
   endfunction

endpackage

// File: rtl/controller_led_channel.sv
// ---------------------------------------------------------------------------
// controller_led_channel
// One LED blink channel: PERIOD register, control bits, half-period counter,
// phase flop and the registered LED output.
// Optional feature macro: CONTROLLER_LED_IRQ_EN (adds IE and sticky PEND).
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset
//   i_period_we  write strobe for this channel's PERIOD word
//   i_ctrl_we    write strobe for this channel's CTRL word
//   i_wdata      bus write data
//   o_period     current PERIOD value
//   o_ctrl       current EN/INV/IE bits
//   o_led        registered LED level (phase ^ INV)
//   o_pend       pending-interrupt flag (0 when the IRQ feature is absent)
// ---------------------------------------------------------------------------
module controller_led_channel
   import controller_led_pkg::*;
#(
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_period_we,
   input  logic                i_ctrl_we,
   input  logic [31:0]         i_wdata,
   output logic [PERIOD_W-1:0] o_period,
   output ctrl_t               o_ctrl,
   output logic                o_led,
   output logic                o_pend
);

   logic [PERIOD_W-1:0] r_period;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] w_cnt_next;
   ctrl_t               r_ctrl;
   ctrl_t               w_ctrl_next;
   logic                r_phase;
   logic                w_phase_next;
   logic                r_led;
   logic                w_active;
   logic                w_toggle;
   logic                w_unused_bits;

   // A zero period behaves exactly like a disabled channel.
   assign w_active = r_ctrl.en && (r_period != '0);

   always_comb begin
      w_ctrl_next = r_ctrl;
      if (i_ctrl_we) begin
         w_ctrl_next.en  = i_wdata[CTRL_EN_BIT];
         w_ctrl_next.inv = i_wdata[CTRL_INV_BIT];
`ifdef CONTROLLER_LED_IRQ_EN
         w_ctrl_next.ie  = i_wdata[CTRL_IE_BIT];
`endif
      end
   end

   // While inactive the counter and phase sit at zero, so an EN 0->1 write
   // naturally starts the count from cnt=0, phase=0. A PERIOD write restarts
   // the count but keeps the phase, and takes priority over a terminal count
   // landing on the same edge.
   always_comb begin
      w_cnt_next   = r_cnt;
      w_phase_next = r_phase;
      w_toggle     = 1'b0;
      if (i_period_we) begin
         w_cnt_next = '0;
      end else if (!w_active) begin
         w_cnt_next   = '0;
         w_phase_next = 1'b0;
      end else if (r_cnt == r_period - PERIOD_W'(1)) begin
         w_cnt_next   = '0;
         w_phase_next = !r_phase;
         w_toggle     = 1'b1;
      end else begin
         w_cnt_next = r_cnt + PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_period <= '0;
         r_ctrl   <= '0;
         r_cnt    <= '0;
         r_phase  <= 1'b0;
         r_led    <= 1'b0;
      end else begin
         if (i_period_we) begin
            r_period <= i_wdata[PERIOD_W-1:0];
         end
         r_ctrl  <= w_ctrl_next;
         r_cnt   <= w_cnt_next;
         r_phase <= w_phase_next;
         // LED is its own flop so the output pin never sees bus logic.
         r_led   <= w_phase_next ^ w_ctrl_next.inv;
      end
   end

`ifdef CONTROLLER_LED_IRQ_EN
   logic r_pend;

   // A toggle setting PEND beats a simultaneous write-1-to-clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= 1'b0;
      end else if (w_toggle && r_ctrl.ie) begin
         r_pend <= 1'b1;
      end else if (i_ctrl_we && i_wdata[CTRL_PEND_BIT]) begin
         r_pend <= 1'b0;
      end
   end

   assign o_pend = r_pend;
`else
   assign o_pend = 1'b0;
`endif

   // Upper write-data bits (and the toggle pulse without IRQs) are not needed.
   assign w_unused_bits = ^{i_wdata, w_toggle};

   assign o_period = r_period;
   assign o_ctrl   = r_ctrl;
   assign o_led    = r_led;

endmodule

// File: rtl/controller_led_blinker.sv
// ---------------------------------------------------------------------------
// controller_led_blinker
// Multi-channel LED blink generator on an Avalon-MM slave. Each channel has a
// PERIOD word (sel=0) and a CTRL word (sel=1) at address {ch, sel}.
// Optional feature macro: CONTROLLER_LED_IRQ_EN (adds the irq output plus
// per-channel IE/PEND bits).
//
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   address     word address {ch, sel}
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data, zero wait states
//   out_port    LED outputs, bit ch = channel ch
//   irq         OR of all PEND bits (IRQ build only)
// ---------------------------------------------------------------------------
module controller_led_blinker
   import controller_led_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int PERIOD_W = 24,
   localparam int AW       = $clog2(CHANNELS) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [AW-1:0]       address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic [CHANNELS-1:0] out_port
`ifdef CONTROLLER_LED_IRQ_EN
   ,
   output logic                irq
`endif
);

   logic                w_wr;
   logic                w_sel;
   logic [AW-1:0]       w_ch;
   logic [PERIOD_W-1:0] w_period [CHANNELS];
   ctrl_t               w_ctrl   [CHANNELS];
   logic [CHANNELS-1:0] w_led;
   logic [CHANNELS-1:0] w_pend;

   assign w_wr  = chipselect && !write_n;
   assign w_sel = address[0];
   // Kept at full address width so channel numbers past CHANNELS-1 simply
   // match no channel and decode to nothing.
   assign w_ch  = address >> 1;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic w_hit;
         assign w_hit = w_wr && (w_ch == AW'(gi));

         controller_led_channel #(
            .PERIOD_W (PERIOD_W)
         ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .i_period_we (w_hit && (w_sel == SEL_PERIOD)),
            .i_ctrl_we   (w_hit && (w_sel == SEL_CTRL)),
            .i_wdata     (writedata),
            .o_period    (w_period[gi]),
            .o_ctrl      (w_ctrl[gi]),
            .o_led       (w_led[gi]),
            .o_pend      (w_pend[gi])
         );
      end
   endgenerate

   always_comb begin
      readdata = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_ch == AW'(i)) begin
            if (w_sel == SEL_PERIOD) begin
               readdata[PERIOD_W-1:0] = w_period[i];
            end else begin
               readdata = pack_ctrl(w_ctrl[i], w_led[i], w_pend[i]);
            end
         end
      end
   end

   assign out_port = w_led;

`ifdef CONTROLLER_LED_IRQ_EN
   // PEND bits are flops, so irq carries no bus-side combinational path.
   assign irq = |w_pend;
`endif

endmodule

// File: tb/tb_controller_led_blinker.sv
`timescale 1ns/1ps
module tb_controller_led_blinker;

   localparam int CH = 3;
   localparam int PW = 8;
   localparam int AW = $clog2(CH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [AW-1:0] address = '0;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic [CH-1:0] out_port;
`ifdef CONTROLLER_LED_IRQ_EN
   logic          irq;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   controller_led_blinker #(.CHANNELS(CH), .PERIOD_W(PW)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
`ifdef CONTROLLER_LED_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // A running channel's phase at edge n is the phase captured at its anchor
   // edge, flipped once per elapsed whole half-period.
   int m_period [CH];
   bit m_en     [CH];
   bit m_inv    [CH];
   int m_a      [CH];
   bit m_ph     [CH];

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         m_period[c] = 0; m_en[c] = 0; m_inv[c] = 0; m_a[c] = 0; m_ph[c] = 0;
      end
   endfunction

   function automatic bit exp_phase(int c, int n);
      if (!m_en[c] || m_period[c] == 0) return 1'b0;
      return m_ph[c] ^ bit'(((n - m_a[c]) / m_period[c]) % 2);
   endfunction

   function automatic logic [CH-1:0] exp_leds(int n);
      logic [CH-1:0] v;
      for (int c = 0; c < CH; c++) v[c] = exp_phase(c, n) ^ m_inv[c];
      return v;
   endfunction

   function automatic void model_write(int c, bit sel, logic [31:0] d, int w);
      if (c >= CH) return;
      if (!sel) begin
         if (m_en[c]) begin
            m_ph[c] = exp_phase(c, w - 1);
            m_a[c]  = w;
         end
         m_period[c] = int'(d[PW-1:0]);
      end else begin
         if (!m_en[c] && d[0]) begin
            m_a[c]  = w;
            m_ph[c] = 1'b0;
         end
         m_en[c]  = d[0];
         m_inv[c] = d[1];
      end
   endfunction

   // ---------------- bus helpers ----------------
   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic bus_write(int c, bit sel, logic [31:0] d);
      address    = AW'((c << 1) | int'(sel));
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
      @(posedge clk); #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      model_write(c, sel, d, cyc);
   endtask

   task automatic bus_read(int c, bit sel, output logic [31:0] d);
      address = AW'((c << 1) | int'(sel));
      #1;
      d = readdata;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      model_reset();
      n_tests++;
      if (out_port !== '0) begin
         n_fail++; $display("FAIL reset_out_port got=%b exp=0", out_port);
      end
`ifdef CONTROLLER_LED_IRQ_EN
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
      for (int a = 0; a < (1 << AW); a++) begin
         bus_read(a >> 1, bit'(a & 1), d);
         n_tests++;
         if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, d);
         end
      end
      bus_write(CH, 1'b0, 32'h0000_00FF);
      bus_write(CH, 1'b1, 32'h0000_0003);
      idle(2);
      for (int a = 0; a < (1 << AW); a++) begin
         bus_read(a >> 1, bit'(a & 1), d);
         n_tests++;
         if (d !== 32'h0) begin
            n_fail++; $display("FAIL oob_write_read addr=%0d got=%h exp=0", a, d);
         end
      end
      n_tests++;
      if (out_port !== '0) begin
         n_fail++; $display("FAIL oob_write_out_port got=%b exp=0", out_port);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_blink(output int e0);
      logic [31:0] d;
      logic [CH-1:0] exp;
      bus_write(0, 1'b0, 32'd3);
      bus_write(0, 1'b1, 32'd1);
      e0 = cyc;
      for (int k = 1; k <= 9; k++) begin
         idle(1);
         exp = {2'b00, 1'(((k / 3) % 2) != 0)};
         n_tests++;
         if (out_port !== exp) begin
            n_fail++; $display("FAIL blink_p3 k=%0d got=%b exp=%b", k, out_port, exp);
         end
         if (k == 4 || k == 7) begin
            bus_read(0, 1'b1, d);
            n_tests++;
            if (d !== {29'd0, exp[0], 2'b01}) begin
               n_fail++; $display("FAIL blink_level k=%0d got=%h exp=%h", k, d, {29'd0, exp[0], 2'b01});
            end
         end
      end
      $display("[TB] test_blink done");
   endtask

   task automatic test_period_change(int e0);
      logic [31:0] d;
      logic ph;
      int w;
      logic exp;
      idle(1);
      bus_write(0, 1'b0, 32'd5);
      w  = cyc;
      ph = 1'(((w - 1 - e0) / 3) % 2);
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) idle(1);
         exp = ph ^ 1'((k / 5) % 2);
         n_tests++;
         if (out_port !== {2'b00, exp}) begin
            n_fail++; $display("FAIL period_change k=%0d got=%b exp=%b", k, out_port, {2'b00, exp});
         end
      end
      bus_write(0, 1'b0, 32'd0);
      idle(2);
      for (int k = 0; k < 5; k++) begin
         idle(1);
         n_tests++;
         if (out_port !== 3'b000) begin
            n_fail++; $display("FAIL period_zero_hold k=%0d got=%b exp=000", k, out_port);
         end
      end
      bus_read(0, 1'b0, d);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL period_zero_read got=%h exp=0", d); end
      bus_write(0, 1'b0, 32'd4);
      for (int k = 1; k <= 9; k++) begin
         idle(1);
         exp = 1'((k / 4) % 2);
         n_tests++;
         if (out_port !== {2'b00, exp}) begin
            n_fail++; $display("FAIL period_restart k=%0d got=%b exp=%b", k, out_port, {2'b00, exp});
         end
      end
      bus_write(0, 1'b1, 32'd0);
      idle(2);
      $display("[TB] test_period_change done");
   endtask

   task automatic test_inv_reset();
      logic [31:0] d;
      logic [31:0] exp_ctrl;
      bus_write(2, 1'b1, 32'd2);
      n_tests++;
      if (out_port !== 3'b100) begin n_fail++; $display("FAIL inv_out got=%b exp=100", out_port); end
      bus_read(2, 1'b1, d);
      n_tests++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL inv_ctrl_read got=%h exp=6", d); end
      bus_write(1, 1'b1, 32'hFFFF_FFFA);
`ifdef CONTROLLER_LED_IRQ_EN
      exp_ctrl = 32'hE;
`else
      exp_ctrl = 32'h6;
`endif
      bus_read(1, 1'b1, d);
      n_tests++;
      if (d !== exp_ctrl) begin n_fail++; $display("FAIL ctrl_upper_bits got=%h exp=%h", d, exp_ctrl); end
      bus_write(0, 1'b0, 32'd2);
      bus_write(0, 1'b1, 32'd1);
      bus_write(1, 1'b0, 32'd7);
      bus_write(1, 1'b1, 32'd3);
      idle(5);
      n_tests++;
      if (out_port !== exp_leds(cyc)) begin
         n_fail++; $display("FAIL pre_reset_blink got=%b exp=%b", out_port, exp_leds(cyc));
      end
      reset      = 1'b1;
      address    = AW'(2);
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = 32'd9;
      @(posedge clk); #1;
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      model_reset();
      n_tests++;
      if (out_port !== '0) begin n_fail++; $display("FAIL midreset_out got=%b exp=0", out_port); end
`ifdef CONTROLLER_LED_IRQ_EN
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq got=%b exp=0", irq); end
`endif
      for (int a = 0; a < 2 * CH; a++) begin
         bus_read(a >> 1, bit'(a & 1), d);
         n_tests++;
         if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_read addr=%0d got=%h exp=0", a, d); end
      end
      idle(3);
      n_tests++;
      if (out_port !== '0) begin n_fail++; $display("FAIL postreset_idle got=%b exp=0", out_port); end
      $display("[TB] test_inv_reset done");
   endtask

   task automatic test_random();
      logic [31:0] d, exp_d;
      int p, len;
      logic [CH-1:0] inv_v;
      for (int it = 0; it < 6; it++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 7) == 0) p = 0;
            else if ($urandom_range(0, 3) == 0) p = $urandom_range(1, 40);
            else p = $urandom_range(1, 6);
            inv_v[c] = 1'($urandom_range(0, 1));
            bus_write(c, 1'b0, ($urandom & 32'hFFFF_FF00) | 32'(p));
            bus_write(c, 1'b1, ($urandom & 32'hFFFF_FFE4) | {30'd0, inv_v[c], 1'b1});
         end
         len = $urandom_range(20, 60);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 9) == 0) bus_write($urandom_range(0, CH - 1), 1'b0, 32'($urandom_range(1, 8)));
            else idle(1);
            n_tests++;
            if (out_port !== exp_leds(cyc)) begin
               n_fail++; $display("FAIL random it=%0d k=%0d got=%b exp=%b", it, k, out_port, exp_leds(cyc));
            end
         end
         for (int c = 0; c < CH; c++) begin
            bus_read(c, 1'b0, d);
            n_tests++;
            if (d !== 32'(m_period[c])) begin
               n_fail++; $display("FAIL random_period ch=%0d got=%h exp=%h", c, d, 32'(m_period[c]));
            end
            exp_d = {29'd0, exp_phase(c, cyc) ^ m_inv[c], m_inv[c], m_en[c]};
            bus_read(c, 1'b1, d);
            n_tests++;
            if (d !== exp_d) begin
               n_fail++; $display("FAIL random_ctrl ch=%0d got=%h exp=%h", c, d, exp_d);
            end
         end
         for (int c = 0; c < CH; c++) bus_write(c, 1'b1, {30'd0, inv_v[c], 1'b0});
         idle(2);
         n_tests++;
         if (out_port !== inv_v) begin
            n_fail++; $display("FAIL random_disable it=%0d got=%b exp=%b", it, out_port, inv_v);
         end
`ifdef CONTROLLER_LED_IRQ_EN
         n_tests++;
         if (irq !== 1'b0) begin n_fail++; $display("FAIL random_irq_ie0 got=%b exp=0", irq); end
`endif
      end
      $display("[TB] test_random done");
   endtask

   task automatic test_boundary();
      logic [31:0] d;
      int e0, e1;
      logic [CH-1:0] exp;
      for (int c = 0; c < CH; c++) bus_write(c, 1'b1, 32'd0);
      bus_write(0, 1'b0, 32'd255);
      bus_write(1, 1'b0, 32'd1);
      bus_write(0, 1'b1, 32'd1);
      e0 = cyc;
      bus_write(1, 1'b1, 32'd1);
      e1 = cyc;
      while (cyc < e0 + 520) begin
         exp = {1'b0, 1'((cyc - e1) % 2), 1'(((cyc - e0) / 255) % 2)};
         n_tests++;
         if (out_port !== exp) begin
            n_fail++; $display("FAIL boundary k0=%0d got=%b exp=%b", cyc - e0, out_port, exp);
         end
         idle(1);
      end
      bus_read(0, 1'b0, d);
      n_tests++;
      if (d !== 32'd255) begin n_fail++; $display("FAIL boundary_period_read got=%h exp=ff", d); end
      bus_write(0, 1'b1, 32'd0);
      bus_write(1, 1'b1, 32'd0);
      idle(2);
      $display("[TB] test_boundary done");
   endtask

`ifdef CONTROLLER_LED_IRQ_EN
   task automatic test_irq();
      logic [31:0] d;
      bus_write(1, 1'b0, 32'd2);
      bus_write(1, 1'b1, 32'h9);
      idle(1);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got=%b exp=0", irq); end
      idle(1);
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_first_toggle got=%b exp=1", irq); end
      bus_read(1, 1'b1, d);
      n_tests++;
      if (d !== 32'h1D) begin n_fail++; $display("FAIL irq_ctrl_read got=%h exp=1d", d); end
      idle(1);
      bus_write(1, 1'b1, 32'h19);
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
      bus_write(1, 1'b1, 32'h19);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", irq); end
      bus_read(1, 1'b1, d);
      n_tests++;
      if (d !== 32'h9) begin n_fail++; $display("FAIL irq_clear_read got=%h exp=9", d); end
      idle(1);
      n_tests++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_reassert got=%b exp=1", irq); end
      bus_write(1, 1'b1, 32'h10);
      idle(1);
      n_tests++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_final_clear got=%b exp=0", irq); end
      $display("[TB] test_irq done");
   endtask
`endif

   initial begin
      int e0;
      model_reset();
      test_reset();
      test_blink(e0);
      test_period_change(e0);
      test_inv_reset();
      test_random();
      test_boundary();
`ifdef CONTROLLER_LED_IRQ_EN
      test_irq();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
